// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream (length word N, then N words) into
// 32-bit code memory writes, then releases the core with core_en.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_en,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [2:0] {IDLE, LEN, LOAD, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [1:0] cnt;
    logic [DATA_W-9:0] sh;
    logic [ADDR_W:0] n;
    logic fin, acc, last, start_ok;
    logic [DATA_W-1:0] word;
    // fin marks the final word as captured; it closes s_ready during that write
    assign s_ready = state == LEN || (state == LOAD && !fin);
    assign acc = s_valid && s_ready;
    assign last = acc && cnt == 2'd3;
    assign word = {sh, s_data};
    assign busy = state == LEN || state == LOAD;
    assign core_en = state == DONE;
    assign err = state == ERR;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN;
            LEN: if (last) state_nx = word == '0 ? DONE : word > DATA_W'(DEPTH) ? ERR : LOAD;
            LOAD: if (mem_we && fin) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            sh <= '0;
            n <= '0;
            fin <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= state == LOAD && last;
            if (acc) begin
                cnt <= cnt + 2'd1;
                sh <= word[DATA_W-9:0];
            end
            if (state == LEN && last) n <= word[ADDR_W:0];
            if (state == LOAD && last) begin
                mem_addr <= words_loaded[ADDR_W-1:0];
                mem_wdata <= word;
                fin <= words_loaded + {{ADDR_W{1'b0}}, 1'b1} == n;
            end
            if (mem_we) words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
            if (start_ok) begin
                cnt <= '0;
                sh <= '0;
                fin <= 1'b0;
                words_loaded <= '0;
            end
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads; expected writes go to a queue that a negedge
// monitor pops and compares (address, data and cycle) on every mem_we.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    logic clk = 0, rst = 1, start = 0, s_valid = 0;
    logic [7:0] s_data = 0;
    logic s_ready, mem_we, core_en, busy, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [ADDR_W:0] words_loaded;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0] data;
        int cyc;
    } wr_t;
    wr_t exp_q[$];
    int errors = 0, checks = 0, cyc = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_en(core_en), .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (!rst && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected write addr=%0d data=%h at cycle %0d", mem_addr, mem_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h cycle=%0d, expected addr=%0d data=%h cycle=%0d",
                             mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit poke);
        int gap, t;
        bit p;
        gap = rnd ? int'($urandom_range(1, 3)) : 0;
        p = poke;
        repeat (gap) begin
            @(posedge clk); #1 start = p;
            p = 0;
        end
        s_data = b;
        s_valid = 1;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 40) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake: s_ready stayed 0 for byte %h, required 1", b);
        end
        @(posedge clk); #1;
        s_valid = 0;
        start = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit push, input logic [ADDR_W-1:0] a,
                             input bit rnd = 0);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], rnd, rnd && push && k == 1);
        if (push) exp_q.push_back('{addr: a, data: w, cyc: cyc});
    endtask

    task automatic finish_load(input int n);
        @(negedge clk);
        check("core_en during last write", 32'(core_en), 0);
        check("s_ready during last write", 32'(s_ready), 0);
        @(negedge clk);
        check("core_en after last write", 32'(core_en), 1);
        check("words_loaded", 32'(words_loaded), 32'(n));
        check("busy in DONE", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"}, 32'(s_ready), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " core_en"}, 32'(core_en), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " err"}, 32'(err), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " words_loaded"}, 32'(words_loaded), 0);
    endtask

    initial begin
        logic [7:0] b8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 0;
        // T1: basic two-word load
        pulse_start();
        check("busy in LEN", 32'(busy), 1);
        send_word(32'd2, 0, 0);
        send_word(32'h2001_0005, 1, 0);
        send_word(32'h0022_1800, 1, 1);
        finish_load(2);
        // T2: zero length goes straight to DONE
        pulse_start();
        check("words_loaded cleared by start", 32'(words_loaded), 0);
        send_word(32'd0, 0, 0);
        @(negedge clk);
        check("N=0 core_en", 32'(core_en), 1);
        check("N=0 words_loaded", 32'(words_loaded), 0);
        check("N=0 busy", 32'(busy), 0);
        // T3: oversize length, bytes offered while in ERR, then recovery
        pulse_start();
        check("core_en cleared by start", 32'(core_en), 0);
        send_word(32'h0000_0021, 0, 0);
        @(negedge clk);
        check("N=33 err", 32'(err), 1);
        check("N=33 s_ready", 32'(s_ready), 0);
        check("N=33 core_en", 32'(core_en), 0);
        s_data = 8'h55;
        s_valid = 1;
        repeat (3) @(negedge clk);
        check("ERR ignores bytes", 32'(s_ready), 0);
        s_valid = 0;
        pulse_start();
        check("err cleared by start", 32'(err), 0);
        check("busy after ERR start", 32'(busy), 1);
        send_word(32'd1, 0, 0);
        send_word(32'hDEAD_BEEF, 1, 0);
        finish_load(1);
        // T4: full depth, back-to-back bytes
        pulse_start();
        send_word(32'd32, 0, 0);
        for (int i = 0; i < 32; i++) begin
            b8 = 8'(i);
            send_word({b8, ~b8, 8'h5A, b8 ^ 8'h3C}, 1, 5'(i));
        end
        finish_load(32);
        // T5: T1 stream with gaps and ignored start pulses
        pulse_start();
        send_word(32'd2, 0, 0, 1);
        send_word(32'h2001_0005, 1, 0, 1);
        send_word(32'h0022_1800, 1, 1, 1);
        finish_load(2);
        // T6: reset in the middle of word 1, then a fresh load
        pulse_start();
        send_word(32'd2, 0, 0);
        send_word(32'h1122_3344, 1, 0);
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        #2 rst = 1;
        #1 check_reset_outputs("mid-load reset");
        @(posedge clk); #1 rst = 0;
        pulse_start();
        send_word(32'd1, 0, 0);
        send_word(32'hCAFE_0001, 1, 0);
        finish_load(1);
        repeat (3) @(negedge clk);
        check("pending expected writes", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
